// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO drain controller: FSM state encoding,
// skid depth and the read-space rule used to bound outstanding FIFO reads.
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } drain_state_e;

    localparam int SKID_DEPTH         = 2;
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int OCC_W              = $clog2(SKID_DEPTH + 1);

    // A new read may issue only if the word it returns will find a free skid slot.
    function automatic logic skid_has_room(
        input logic [OCC_W-1:0] occ,
        input logic             inflight,
        input logic             pop
    );
        logic [OCC_W:0] w_used;
        w_used = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
        return w_used < ((OCC_W+1)'(SKID_DEPTH) + {{OCC_W{1'b0}}, pop});
    endfunction

endpackage

// File: rtl/fifo_drain_skid.sv
// Two-entry, FIFO-ordered skid buffer between the FIFO read port and the
// output stream; the head entry drives the stream directly.
module fifo_drain_skid
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [OCC_W-1:0]      o_occ,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic [OCC_W-1:0]      r_occ;
    logic                  w_pop;

    assign w_pop   = i_pop & (r_occ != '0);
    assign o_occ   = r_occ;
    assign o_valid = (r_occ != '0);
    assign o_data  = r_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_occ == '0) r_head <= i_push_data;
                    else             r_tail <= i_push_data;
                    r_occ <= r_occ + OCC_W'(1);
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_occ  <= r_occ - OCC_W'(1);
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word lands behind whatever remains.
                    if (r_occ == OCC_W'(1)) begin
                        r_head <= i_push_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-side FIFO drain controller: issues bounded reads for an N-word command
// and streams the returned words out through a skid. FIFO_DRAIN_CNT_EN adds word_cnt.
module fifo_drain_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LEN_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    input  logic [LEN_W-1:0]      cmd_len,
    output logic                  cmd_ready,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            dbg_state
`ifdef FIFO_DRAIN_CNT_EN
    ,
    output logic [31:0]           word_cnt
`endif
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_READ  = READ;
    localparam logic [1:0] S_DRAIN = DRAIN;
    localparam logic [1:0] S_DONE  = DONE;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_issue_cnt;
    logic [LEN_W-1:0] r_deliver_cnt;
    logic             r_inflight;
    logic             r_rst_q;
    logic [OCC_W-1:0] w_occ;
    logic             w_pop;
    logic             w_accept;
    logic             w_rd_en;
    logic             w_last_issue;
    logic             w_all_delivered;

    // Handshakes: a command transfers on cmd_valid & cmd_ready at a rising edge,
    // a stream word on m_valid & m_ready; a FIFO read is accepted whenever fifo_rd_en is high.
    assign w_pop     = m_valid & m_ready;
    assign cmd_ready = (r_state == S_IDLE) & ~r_rst_q;
    assign w_accept  = cmd_valid & cmd_ready;

    assign w_rd_en = (r_state == S_READ) & ~fifo_empty & (r_issue_cnt < r_len)
                   & skid_has_room(w_occ, r_inflight, w_pop);
    assign fifo_rd_en = w_rd_en;

    assign w_last_issue    = w_rd_en & ((r_issue_cnt + LEN_W'(1)) == r_len);
    assign w_all_delivered = ({1'b0, r_deliver_cnt} + (LEN_W+1)'(w_pop)) == {1'b0, r_len};

    assign busy      = (r_state == S_READ) | (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);
    assign dbg_state = r_state;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_next = (cmd_len == '0) ? S_DONE : S_READ;
            end
            S_READ: begin
                if (w_last_issue) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                // Leave as the final pop happens so done follows that pop edge directly.
                if (~r_inflight & w_all_delivered) w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_len         <= '0;
            r_issue_cnt   <= '0;
            r_deliver_cnt <= '0;
            r_inflight    <= 1'b0;
            r_rst_q       <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_rd_en;
            r_rst_q    <= 1'b0;
            if (w_accept) begin
                r_len         <= cmd_len;
                r_issue_cnt   <= '0;
                r_deliver_cnt <= '0;
            end else begin
                if (w_rd_en) r_issue_cnt   <= r_issue_cnt + LEN_W'(1);
                if (w_pop)   r_deliver_cnt <= r_deliver_cnt + LEN_W'(1);
            end
        end
    end

    // A word returning after a reset finds r_inflight cleared and is dropped.
    fifo_drain_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight),
        .i_push_data (fifo_data),
        .i_pop       (m_ready),
        .o_occ       (w_occ),
        .o_valid     (m_valid),
        .o_data      (m_data)
    );

`ifdef FIFO_DRAIN_CNT_EN
    logic [31:0] r_word_cnt;

    always_ff @(posedge clk) begin
        if (rst)        r_word_cnt <= '0;
        else if (w_pop) r_word_cnt <= r_word_cnt + 32'd1;
    end

    assign word_cnt = r_word_cnt;
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Scoreboard bench for fifo_drain_ctrl: FIFO model, directed and random transfers,
// stream order/stability/bound checks from a monitor process.
module tb_fifo_drain_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [7:0]  cmd_len;
    logic        cmd_ready;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  fifo_data = 8'h00;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        busy;
    logic        done;
    logic [1:0]  dbg_state;
`ifdef FIFO_DRAIN_CNT_EN
    logic [31:0] word_cnt;
`endif

    always #5 clk = ~clk;

    fifo_drain_ctrl #(.DATA_WIDTH(8), .LEN_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_len    (cmd_len),
        .cmd_ready  (cmd_ready),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
`ifdef FIFO_DRAIN_CNT_EN
        ,
        .word_cnt   (word_cnt)
`endif
    );

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // FIFO model: registered read data, contents discarded while rst is high.
    logic [7:0] fifo_mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (rst) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en && rd_ptr != wr_ptr) begin
            fifo_data <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic push_word(input logic [7:0] w, input bit track);
        fifo_mem[wr_ptr] = w;
        wr_ptr++;
        if (track) exp_q.push_back(w);
    endtask

    task automatic push_random(input int n);
        for (int i = 0; i < n; i++) push_word(8'($urandom_range(0, 255)), 1'b1);
    endtask

    // Downstream ready pattern generator.
    int rdy_mode = 0;
    initial begin
        int k;
        k = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: m_ready = 1'b1;
                1: begin
                    m_ready = (k % 4 == 0) || (k % 4 == 3);
                    k++;
                end
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: samples mid-cycle, pops the scoreboard on every stream transfer.
    int n_rd = 0, n_pop = 0, n_done = 0, cyc = 0;
    int out_rd = 0, out_pop = 0, pops_since_reset = 0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    bit capture = 1'b0;
    int first_rd_cyc = -1;
    int pop_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            out_rd = 0;
            out_pop = 0;
            pops_since_reset = 0;
            prev_stall = 1'b0;
        end else begin
            check("outstanding_le_2", ((out_rd - out_pop) <= 2) ? 32'd1 : 32'd0, 32'd1);
            if (prev_stall) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_data", 32'(m_data), 32'(prev_data));
            end
            if (fifo_rd_en) begin
                check("rd_while_empty", 32'(fifo_empty), 32'd0);
                n_rd++;
                out_rd++;
                if (capture && first_rd_cyc < 0) first_rd_cyc = cyc;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h required none at %0t", m_data, $time);
                end else begin
                    check("stream_data", 32'(m_data), 32'(exp_q.pop_front()));
                end
                n_pop++;
                out_pop++;
                pops_since_reset++;
                if (capture) pop_cyc.push_back(cyc);
            end
            if (done) begin
                n_done++;
                check("busy_at_done", 32'(busy), 32'd0);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic apply_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Returns just after the accepting edge.
    task automatic do_cmd(input int len);
        int c;
        bit ok;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_len   = 8'(len);
        c = 0;
        ok = 1'b0;
        while (!ok && c < 50) begin
            @(negedge clk);
            ok = cmd_ready;
            c++;
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL cmd_accept_timeout: got cmd_ready=0 required 1");
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int c;
        c = 0;
        while (n_done == d0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        if (n_done == d0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got no done after %0d cycles required a pulse", budget);
        end
    endtask

    task automatic finish_xfer(input int len, input int rd0, input int d0);
        wait_done(d0, 500);
        repeat (2) @(posedge clk);
        #1;
        check("rd_count", 32'(n_rd - rd0), 32'(len));
        check("done_pulses", 32'(n_done - d0), 32'd1);
    endtask

    task automatic run_xfer(input int len);
        int rd0, d0;
        rd0 = n_rd;
        d0  = n_done;
        do_cmd(len);
        finish_xfer(len, rd0, d0);
    endtask

    initial begin
        int rd0, d0, c, len;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_len = 8'd0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Basic transfer with latency and back-to-back delivery
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) push_word(8'h11 + 8'(i), 1'b1);
        capture = 1'b1;
        first_rd_cyc = -1;
        pop_cyc.delete();
        run_xfer(4);
        capture = 1'b0;
        check("basic_pops", 32'(pop_cyc.size()), 32'd4);
        if (pop_cyc.size() == 4) begin
            check("basic_latency", 32'(pop_cyc[0] - first_rd_cyc), 32'd2);
            for (int i = 1; i < 4; i++) check("basic_consecutive", 32'(pop_cyc[i] - pop_cyc[0]), 32'(i));
        end

        // Backpressure
        rdy_mode = 1;
        push_random(6);
        run_xfer(6);
        rdy_mode = 0;

        // Empty stall and resume
        push_random(2);
        rd0 = n_rd;
        d0  = n_done;
        do_cmd(5);
        repeat (10) @(posedge clk);
        #1;
        push_random(3);
        @(negedge clk);
        check("rd_resume", 32'(fifo_rd_en), 32'd1);
        finish_xfer(5, rd0, d0);

        // Zero length
        rd0 = n_rd;
        do_cmd(0);
        @(negedge clk);
        check("zero_done", 32'(done), 32'd1);
        check("zero_cmd_ready_low", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("zero_done_low", 32'(done), 32'd0);
        check("zero_cmd_ready_back", 32'(cmd_ready), 32'd1);
        check("zero_rd_count", 32'(n_rd - rd0), 32'd0);

        // Reset mid-transfer
        for (int i = 0; i < 4; i++) push_word(8'($urandom_range(0, 255)), 1'b0);
        do_cmd(4);
        c = 0;
        while (!fifo_rd_en && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("midrst_saw_rd", 32'(fifo_rd_en), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_m_valid", 32'(m_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_no_stale_1", 32'(m_valid), 32'd0);
        @(negedge clk);
        check("midrst_no_stale_2", 32'(m_valid), 32'd0);
        exp_q.delete();
        push_word(8'hA5, 1'b1);
        run_xfer(1);

        // Randomized transfers under random backpressure
        rdy_mode = 2;
        for (int t = 0; t < 6; t++) begin
            len = $urandom_range(1, 16);
            push_random(len);
            run_xfer(len);
        end
        rdy_mode = 0;

`ifdef FIFO_DRAIN_CNT_EN
        check("word_cnt_model", word_cnt, 32'(pops_since_reset));
        apply_reset();
        push_random(3);
        run_xfer(3);
        push_random(4);
        run_xfer(4);
        check("word_cnt_seven", word_cnt, 32'd7);
`endif

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_drain_ctrl.md
# fifo_drain_ctrl

Read-side controller for the team's synchronous FIFO. It accepts a transfer command of N words and issues FIFO read enables. It captures the FIFO's registered read data one cycle later and presents it as a valid/ready stream to downstream logic. A 2-entry skid buffer gives full 1-word/cycle throughput under backpressure without ever over-reading the FIFO.

## Interface
- DATA_WIDTH, 8, width of FIFO words and stream data
- LEN_W, 8, width of the transfer length field
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  transfer request
- cmd_len  input  LEN_W  number of words to drain (0 allowed)
- cmd_ready  output  1  high only in IDLE
- fifo_empty  input  1  FIFO empty flag
- fifo_rd_en  output  1  FIFO read enable (combinational)
- fifo_data  input  DATA_WIDTH  FIFO registered read data, valid the cycle after a read is accepted
- m_valid  output  1  stream data valid
- m_ready  input  1  downstream accept
- m_data  output  DATA_WIDTH  stream data
- busy  output  1  high in READ and DRAIN
- done  output  1  one-cycle pulse when a transfer completes

## Operation
- States:
  - IDLE: cmd_ready=1. cmd_valid sampled high with cmd_len>0 → READ; with cmd_len=0 → DONE.
  - READ: issue reads until issued==cmd_len, then → DRAIN.
  - DRAIN: wait until inflight=0 and skid empty → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Counters: issue_cnt and deliver_cnt are LEN_W wide, cleared on command accept; the command length is latched.
- fifo_rd_en = (state==READ) & !fifo_empty & (issue_cnt<len) & (occ + inflight − pop < 2).
  - occ: skid occupancy, 0..2.
  - inflight: rd_en issued last cycle.
  - pop: m_valid & m_ready.
- When inflight=1, fifo_data is written into the skid at the next edge, unconditionally. The space rule guarantees room.
- Skid is FIFO-ordered; m_data = head entry, m_valid = (occ>0).
- Words reach the stream in exactly FIFO order; no word is dropped or duplicated.
- m_data holds stable while m_valid & !m_ready.
- A simultaneous push and pop keeps occ unchanged.
- Reset values: cmd_ready=0 during reset and 1 after, fifo_rd_en=0, m_valid=0, m_data=0, busy=0, done=0, state=IDLE, occ=0, inflight=0.
- Reset mid-transfer: all state cleared; an in-flight word returning next cycle is discarded.

## Timing
- Read-to-stream latency: rd_en high in cycle t → fifo_data valid in t+1 → m_valid in t+2.
- Throughput: 1 word/cycle sustained when m_ready=1 and the FIFO is non-empty.
- Bounded reads: at most 2 words outstanding (occ + inflight ≤ 2) at any time.
- fifo_empty rising mid-transfer: reads pause with no extra rd_en; they resume the cycle fifo_empty falls.
- Combinational paths: m_ready→fifo_rd_en and fifo_empty→fifo_rd_en; no other input→output paths.
- done asserts the cycle after the last word's pop edge, when inflight=0 and occ=0.
- Length counter wrap: LEN_W counters never exceed 2^LEN_W−1; no wrap occurs.

## Configuration
- FIFO_DRAIN_CNT_EN defined: adds output word_cnt [31:0], the total words popped on the stream since reset.
  - Increments on each pop and wraps at 2^32.
  - Reset to 0; not cleared between commands.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package fifo_pkg holds:
  - the state enum (IDLE, READ, DRAIN, DONE);
  - SKID_DEPTH=2;
  - the default DATA_WIDTH.
- One sub-module, fifo_drain_skid: 2-entry skid buffer with push/pop/occ, m_valid, m_data.
- The FSM, counters and rd_en logic stay in the top module.

## Test plan
- Basic transfer: FIFO holds 0x11..0x14, cmd_len=4, m_ready=1.
  - Expect 4 rd_en cycles, m_data 0x11,0x12,0x13,0x14 on consecutive cycles starting 2 cycles after the first rd_en.
  - done pulses once; busy falls with done.
- Backpressure: cmd_len=6, m_ready toggling 1,0,0,1 repeatedly.
  - Order preserved, m_data stable while stalled.
  - occ+inflight never exceeds 2, and exactly 6 rd_en are issued.
- Empty stall: FIFO holds 2 words, cmd_len=5; push 3 more words 10 cycles later.
  - No rd_en while fifo_empty=1; all 5 words delivered, then done.
- Zero length: cmd_len=0.
  - No rd_en; done one cycle after accept; cmd_ready returns high the cycle after that.
- Reset mid-transfer: assert rst the cycle after an rd_en.
  - Next cycle m_valid=0, busy=0, state IDLE; returning data is not presented.
  - A new cmd_len=1 then works normally.
- Counter, FIFO_DRAIN_CNT_EN defined: two transfers of 3 and 4 words.
  - word_cnt reads 7 after the second done.
